wb_stage_rf: RTL

Parametrised writeback stage with integrated register file for the pipelined processor. Selects the writeback result from ALU, memory or link sources. Aligns and sign/zero-extends sub-word loads, then commits the result to the register file. Serves the decode stage's two read ports with same-cycle write bypass, and keeps a retired-instruction counter. Sits after the MEM/WB pipeline register; its inputs are that register's outputs.

---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_load_align.sv | 56 +++++
 rtl/wb_stage_rf.sv | 85 ++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and default sizes for the writeback stage.
package wb_pkg;

  localparam int DEFAULT_DATA_W   = 32;
  localparam int DEFAULT_NUM_REGS = 32;

  // Writeback result source; the unused encoding 2'b11 falls back to the ALU.
  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_MEM  = 2'b01,
    SRC_LINK = 2'b10
  } result_src_t;

  // Load access size; LS_DWORD only has meaning on a 64-bit datapath.
  typedef enum logic [1:0] {
    LS_BYTE  = 2'b00,
    LS_HALF  = 2'b01,
    LS_WORD  = 2'b10,
    LS_DWORD = 2'b11
  } load_size_t;

endpackage

// File: rtl/wb_load_align.sv
// Little-endian sub-word extraction and sign/zero extension of a loaded word.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic [DATA_W-1:0] read_data,
  input  logic [OFF_W-1:0]  byte_off,
  input  logic [1:0]        load_size,
  input  logic              load_unsigned,
  output logic [DATA_W-1:0] load_result
);

  logic [OFF_W-1:0]  eff_off;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] msb_bit;
  logic              sign;

  // Pick the effective byte offset (aligned to the access size) and the field width mask.
  always_comb begin
    eff_off = '0;
    mask    = '1;
    case (load_size_t'(load_size))
      LS_BYTE: begin
        eff_off = byte_off;
        mask    = {{(DATA_W-8){1'b0}}, 8'hFF};
      end
      LS_HALF: begin
        eff_off = {byte_off[OFF_W-1:1], 1'b0};
        mask    = {{(DATA_W-16){1'b0}}, 16'hFFFF};
      end
      LS_WORD: begin
        // On a 32-bit datapath a word is the whole bus; on 64 bits only the upper offset bit selects the half.
        if (DATA_W == 64) begin
          eff_off = {byte_off[OFF_W-1], {(OFF_W-1){1'b0}}};
          mask    = {DATA_W{1'b1}} >> (DATA_W - 32);
        end
      end
      default: begin
        eff_off = '0;
        mask    = '1;
      end
    endcase
  end

  // Shift the addressed field down, then fill the upper bits with its sign or with zeros.
  always_comb begin
    shifted     = read_data >> {eff_off, 3'b000};
    msb_bit     = mask ^ (mask >> 1);
    sign        = (|(shifted & msb_bit)) & ~load_unsigned;
    load_result = (shifted & mask) | (sign ? ~mask : '0);
  end

endmodule

// File: rtl/wb_stage_rf.sv
// Writeback stage: result selection, register file with write bypass, retired-instruction counter.
module wb_stage_rf
  import wb_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int OFF_W    = $clog2(DATA_W/8),
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_w,
  input  logic              reg_write_w,
  input  logic [1:0]        result_src_w,
  input  logic [1:0]        load_size_w,
  input  logic              load_unsigned_w,
  input  logic [OFF_W-1:0]  byte_off_w,
  input  logic [DATA_W-1:0] alu_out_w,
  input  logic [DATA_W-1:0] read_data_w,
  input  logic [DATA_W-1:0] pc_plus4_w,
  input  logic [ADDR_W-1:0] write_reg_w,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] result_w,
  output logic              wr_en_w,
  output logic [CNT_W-1:0]  retired_count
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] load_result;
  logic [CNT_W-1:0]  count;

  wb_load_align #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_align (
    .read_data     (read_data_w),
    .byte_off      (byte_off_w),
    .load_size     (load_size_w),
    .load_unsigned (load_unsigned_w),
    .load_result   (load_result)
  );

  // Choose the writeback value and qualify the write strobe; register 0 is never a target.
  always_comb begin
    case (result_src_t'(result_src_w))
      SRC_MEM:  result_w = load_result;
      SRC_LINK: result_w = pc_plus4_w;
      default:  result_w = alu_out_w;
    endcase
    wr_en_w = valid_w & reg_write_w & (write_reg_w != '0);
  end

  // Register array: cleared asynchronously, written at the end of a cycle with wr_en_w set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en_w) begin
      regs[write_reg_w] <= result_w;
    end
  end

  // Read ports see the in-flight write directly so decode never reads a stale value.
  always_comb begin
    rd_data_a = (wr_en_w && (rd_addr_a == write_reg_w)) ? result_w : regs[rd_addr_a];
    rd_data_b = (wr_en_w && (rd_addr_b == write_reg_w)) ? result_w : regs[rd_addr_b];
  end

  // Count every valid WB slot, wrapping naturally at the counter width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (valid_w) begin
      count <= count + 1'b1;
    end
  end

  assign retired_count = count;

endmodule
